// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA raster scan generator for the Doodle Jump video pipeline.
// Divides the system clock down to the pixel rate and drives the DrawX/DrawY
// coordinates. Registers the color mapper reply one pixel later, together with
// aligned sync and blank. Also provides a per-frame strobe and frame counter.
module vga_scan_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Red_in,
  input  logic [7:0] Green_in,
  input  logic [7:0] Blue_in,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pix_en,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST       = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST       = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_en_q, pix_en_d;
  logic [9:0]       hc_q, hc_d;
  logic [9:0]       vc_q, vc_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             blank_n_q, blank_n_d;
  logic [7:0]       red_q, red_d;
  logic [7:0]       green_q, green_d;
  logic [7:0]       blue_q, blue_d;
  logic             frame_start_q, frame_start_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             visible;

  assign visible = (hc_q < H_VIS) && (vc_q < V_VIS);

  // Pixel-rate divider; pix_en is registered so it is high while div_cnt sits at its last value.
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    pix_en_d  = (div_cnt_d == DIV_LAST);
  end

  // Raster counters step once per pixel period and run straight through blanking.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en_q) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  // Output stage captures sync/blank/color for the pixel being left, one pixel behind DrawX/DrawY.
  always_comb begin
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    red_d     = red_q;
    green_d   = green_q;
    blue_d    = blue_q;
    if (pix_en_q) begin
      hs_d      = !((hc_q >= H_SYNC_START) && (hc_q < H_SYNC_END));
      vs_d      = !((vc_q >= V_SYNC_START) && (vc_q < V_SYNC_END));
      blank_n_d = visible;
      red_d     = visible ? Red_in   : 8'd0;
      green_d   = visible ? Green_in : 8'd0;
      blue_d    = visible ? Blue_in  : 8'd0;
    end
  end

  // Frame strobe fires in the first cycle that shows (0, V_VISIBLE); the count bumps as it ends.
  always_comb begin
    frame_start_d = pix_en_q && (hc_d == 10'd0) && (vc_d == V_VIS);
    frame_cnt_d   = frame_start_q ? frame_cnt_q + 8'd1 : frame_cnt_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt_q     <= '0;
      pix_en_q      <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_en_q      <= pix_en_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign pix_en      = pix_en_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_R       = red_q;
  assign VGA_G       = green_q;
  assign VGA_B       = blue_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Testbench for vga_scan_gen using a shrunken raster so that hundreds of frames fit in a short run.
// The reference model derives every output from the number of Clk cycles since reset release.
module tb_vga_scan_gen;

  localparam int HV = 4, HFP = 1, HSW = 2, HBP = 3;
  localparam int VV = 3, VFP = 1, VSW = 2, VBP = 2;
  localparam int CD = 2;
  localparam int HT = HV + HFP + HSW + HBP;
  localparam int VT = VV + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [7:0] redIn, greenIn, blueIn;
  logic [9:0] drawX, drawY;
  logic       pixEn, vgaHs, vgaVs, vgaBlankN, frameStart;
  logic [7:0] vgaR, vgaG, vgaB, frameCnt;

  int checkCount = 0;
  int errorCount = 0;
  int cyc = 0;
  logic [23:0] sampledRgb = '0;

  vga_scan_gen #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .CLK_DIV(CD)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Red_in(redIn), .Green_in(greenIn), .Blue_in(blueIn),
    .DrawX(drawX), .DrawY(drawY), .pix_en(pixEn),
    .VGA_HS(vgaHs), .VGA_VS(vgaVs), .VGA_BLANK_N(vgaBlankN),
    .VGA_R(vgaR), .VGA_G(vgaG), .VGA_B(vgaB),
    .frame_start(frameStart), .frame_cnt(frameCnt)
  );

  always #5 Clk = ~Clk;

  // Single comparison point: counts every check and reports any disagreement.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Random color mapper reply for the current cycle.
  task automatic applyStimulus();
    redIn   = 8'($urandom);
    greenIn = 8'($urandom);
    blueIn  = 8'($urandom);
  endtask

  // All outputs must sit at their reset values.
  task automatic checkReset(input string tag);
    checkOutput({tag, "/DrawX"}, 32'(drawX), 0);
    checkOutput({tag, "/DrawY"}, 32'(drawY), 0);
    checkOutput({tag, "/pix_en"}, 32'(pixEn), 0);
    checkOutput({tag, "/VGA_HS"}, 32'(vgaHs), 1);
    checkOutput({tag, "/VGA_VS"}, 32'(vgaVs), 1);
    checkOutput({tag, "/BLANK_N"}, 32'(vgaBlankN), 0);
    checkOutput({tag, "/VGA_R"}, 32'(vgaR), 0);
    checkOutput({tag, "/VGA_G"}, 32'(vgaG), 0);
    checkOutput({tag, "/VGA_B"}, 32'(vgaB), 0);
    checkOutput({tag, "/frame_start"}, 32'(frameStart), 0);
    checkOutput({tag, "/frame_cnt"}, 32'(frameCnt), 0);
  endtask

  // Reference model: cycle cyc (1-based since release) has seen (cyc-1)/CD pixel advances.
  task automatic checkCycle();
    int p, q, qx, qy, fsBefore;
    logic expHs, expVs, expBl, expFs;
    logic [23:0] expRgb;
    p = (cyc - 1) / CD;
    checkOutput("DrawX", 32'(drawX), 32'(p % HT));
    checkOutput("DrawY", 32'(drawY), 32'((p / HT) % VT));
    checkOutput("pix_en", 32'(pixEn), 32'(cyc % CD == 0));
    if (p == 0) begin
      expHs = 1'b1; expVs = 1'b1; expBl = 1'b0; expRgb = '0;
    end else begin
      q  = p - 1;
      qx = q % HT;
      qy = (q / HT) % VT;
      expHs  = !(qx >= HV + HFP && qx < HV + HFP + HSW);
      expVs  = !(qy >= VV + VFP && qy < VV + VFP + VSW);
      expBl  = (qx < HV) && (qy < VV);
      expRgb = expBl ? sampledRgb : 24'd0;
    end
    checkOutput("VGA_HS", 32'(vgaHs), 32'(expHs));
    checkOutput("VGA_VS", 32'(vgaVs), 32'(expVs));
    checkOutput("BLANK_N", 32'(vgaBlankN), 32'(expBl));
    checkOutput("VGA_R", 32'(vgaR), 32'(expRgb[23:16]));
    checkOutput("VGA_G", 32'(vgaG), 32'(expRgb[15:8]));
    checkOutput("VGA_B", 32'(vgaB), 32'(expRgb[7:0]));
    expFs = ((cyc - 1) % CD == 0) && (p % FRAME == VV * HT);
    checkOutput("frame_start", 32'(frameStart), 32'(expFs));
    if (cyc - 2 - VV * HT * CD >= 0)
      fsBefore = (cyc - 2 - VV * HT * CD) / (FRAME * CD) + 1;
    else
      fsBefore = 0;
    checkOutput("frame_cnt", 32'(frameCnt), 32'(fsBefore % 256));
  endtask

  // Run cycles from a negedge: drive, check, note what the DUT samples, advance.
  task automatic runCycles(input int count);
    for (int i = 0; i < count; i++) begin
      applyStimulus();
      #1;
      checkCycle();
      if (cyc % CD == 0) sampledRgb = {redIn, greenIn, blueIn};
      cyc++;
      @(negedge Clk);
    end
  endtask

  // Main sequence: reset, long free run across frame_cnt wrap, mid-frame reset, restart.
  initial begin
    int target, guard;
    Reset_n = 1'b1;
    redIn = '0; greenIn = '0; blueIn = '0;
    #2 Reset_n = 1'b0;
    #1 checkReset("rst_async");
    repeat (5) begin
      @(negedge Clk);
      applyStimulus();
    end
    #1 checkReset("rst_held");
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc = 1;
    $display("[TB] free run over 257 frames");
    runCycles(257 * FRAME * CD + 40);

    target = $urandom_range(0, VV - 1) * HT + HV + HFP + 1;
    guard = 0;
    while (!((((cyc - 1) / CD) % FRAME == target) && ((cyc - 1) % CD == 0)) && guard < FRAME * CD + 4) begin
      runCycles(1);
      guard++;
    end
    checkOutput("midframe_reach", 32'(guard < FRAME * CD + 4), 1);
    checkOutput("midframe_hs_low", 32'(vgaHs), 0);
    #3 Reset_n = 1'b0;
    #1 checkReset("rst_midframe");
    repeat (4) @(negedge Clk);
    checkReset("rst_mid_held");
    Reset_n = 1'b1;
    cyc = 1;
    $display("[TB] restart after mid-frame reset");
    runCycles(2 * FRAME * CD + 20);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Display-side scan generator for the Doodle Jump video pipeline. It divides the 50 MHz system clock down to a 25 MHz pixel rate and drives the DrawX/DrawY raster coordinates consumed by the color mapper. It registers the color mapper's Red/Green/Blue reply one pixel later, together with aligned sync and blank signals for the VGA DAC. It also emits a per-frame strobe and frame counter for game-logic updates.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
- CLK_DIV, 2, Clk cycles per pixel (>= 2)
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  reset, asynchronous, active-low
- Red_in, Green_in, Blue_in  in  8 each  color mapper output for current DrawX/DrawY
- DrawX  out  10  current horizontal counter, 0..H_TOTAL-1
- DrawY  out  10  current vertical counter, 0..V_TOTAL-1
- pix_en  out  1  one-Clk strobe marking the last Clk cycle of each pixel period
- VGA_HS  out  1  horizontal sync, active-low
- VGA_VS  out  1  vertical sync, active-low
- VGA_BLANK_N  out  1  high while the output pixel is visible
- VGA_R, VGA_G, VGA_B  out  8 each  registered pixel color
- frame_start  out  1  one-Clk pulse at the start of vertical blanking
- frame_cnt  out  8  frames completed, wraps 255 -> 0

Decided: one clock; reset is asynchronous and active-low.

## Operation
- Divider div_cnt counts 0..CLK_DIV-1 and wraps. pix_en is registered, high exactly when div_cnt == CLK_DIV-1.
- Counter stage advances on the Clk edge ending a pix_en cycle:
  - hc = hc+1, or 0 at H_TOTAL-1.
  - On hc wrap, vc = vc+1, or 0 at V_TOTAL-1.
  - DrawX = hc, DrawY = vc. Counters run through blanking; the color mapper must ignore coordinates of 640 or more and 480 or more.
- Output stage loads on the same edge, from the pre-advance hc/vc:
  - VGA_HS = 0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751).
  - VGA_VS = 0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491).
  - VGA_BLANK_N = (hc < H_VISIBLE) && (vc < V_VISIBLE).
  - VGA_R/G/B = the *_in values when visible, else 0.
- frame_start is high for exactly one Clk cycle: the first Clk cycle in which DrawX=0 and DrawY=V_VISIBLE. frame_cnt increments on the edge ending that cycle.
- All comparisons are unsigned on 10 bits. Parameter sums must fit in 10 bits; no saturation.

## Timing
- Reset values (immediate on Reset_n low, no clock needed):
  - div_cnt = 0, DrawX = 0, DrawY = 0, pix_en = 0
  - VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0, VGA_R/G/B = 0
  - frame_start = 0, frame_cnt = 0
- After release, the first pix_en is in the CLK_DIV-th Clk cycle. DrawX becomes 1 on the edge ending that cycle.
- DrawX/DrawY are stable for CLK_DIV Clk cycles. The color mapper is combinational, and *_in are sampled on the edge ending pix_en.
- Pipeline latency: VGA_* show pixel (x,y) during the pixel period in which DrawX/DrawY show the next coordinate, i.e. one pixel period (CLK_DIV Clk cycles) later. Sync, blank and color are mutually aligned.
- Line = 800 pixel periods; frame = 525 lines = 420000 pixel periods = 840000 Clk cycles at CLK_DIV=2.
- Wrap at (799,524) goes to (0,0) in one step; no extra cycle.
- Reset asserted mid-frame aborts the frame. No frame_start is issued for it, and scanning restarts from (0,0).

## Test plan
- Reset: Reset_n low for 5 cycles -> all outputs at reset values. After release with CLK_DIV=2 -> pix_en high in cycle 2 and every 2nd cycle after; DrawX reaches 1 after cycle 2.
- Line timing: count pix_en between successive DrawX=0 -> 800. VGA_HS low for exactly 96 pixel periods, first low while DrawX=657. VGA_BLANK_N falls while DrawX=641.
- Frame timing: DrawY wraps after 525 lines. VGA_VS low for 2 lines, first low while DrawY=490, DrawX=1. frame_start pulses exactly once per 840000 Clk cycles, when DrawY=480 and DrawX=0.
- Pipeline: drive Red_in = DrawX[7:0], Blue_in = DrawY[7:0] -> while visible, VGA_R equals the previous DrawX[7:0]. VGA_R=VGA_G=VGA_B=0 for the output pixel hc=640 and for all of lines 480..524.
- Async reset: pull Reset_n low between Clk edges at DrawX=300, DrawY=100 -> DrawX/DrawY=0 and VGA_HS=1 before the next edge. No frame_start follows until a full 480 lines after release.
- Counter wrap: run 256 frames -> frame_cnt goes 255 -> 0 on the 256th frame_start. DrawX/DrawY go from (799,524) to (0,0) in one pixel period.
